// File: rtl/flash_ctrl_if.sv
// Host-side request/response bundle for the parallel NOR flash controller.
// Purely combinational wiring; no latency of its own.
// No backpressure: requests are only honoured while the controller is idle.
interface flash_ctrl_if;
   logic       rd_req;
   logic       wr_req;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       busy;
   logic       done;

   // Requester side
   modport master (
      output rd_req, wr_req, addr, wdata,
      input  rdata, busy, done
   );

   // Controller side
   modport slave (
      input  rd_req, wr_req, addr, wdata,
      output rdata, busy, done
   );
endinterface

// File: rtl/flash_ctrl.sv
// Single-byte parallel NOR flash read/write controller with programmable setup/pulse/hold timing.
// Latency: done pulses SETUP_CYC+PULSE_CYC+HOLD_CYC cycles after the accepting edge, idle one cycle later.
// Backpressure: busy is high outside IDLE; requests seen while busy are dropped, never queued.
module flash_ctrl #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 3,
   parameter int HOLD_CYC  = 1
) (
   input  logic         CLK,
   input  logic         RST,
   flash_ctrl_if.slave  host,
   output logic [7:0]   NF_A,
   inout  wire  [7:0]   NF_D,
   output logic         NF_CE,
   output logic         NF_OE,
   output logic         NF_WE,
   output logic         NF_BYTE,
   output logic         NF_RP,
   output logic         NF_WP
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_PULSE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Counter reload values: a timed state lasts (reload + 1) cycles.
   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wr_op_q, wr_op_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       ce_q, ce_d;
   logic       oe_q, oe_d;
   logic       we_q, we_d;
   logic       drv_q, drv_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       active_d;

   // Next-state, counter, request capture and read-data capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_op_d = wr_op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            // A write wins over a simultaneous read.
            if (host.wr_req || host.rd_req) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
               wr_op_d = host.wr_req;
               addr_d  = host.addr;
               wdata_d = host.wdata;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_PULSE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
               // Sample the flash output on the edge that ends the strobe.
               if (!wr_op_q) begin
                  rdata_d = NF_D;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Pin levels decoded from the next state so every strobe comes straight from a flop.
   always_comb begin
      active_d = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
      ce_d     = !active_d;
      oe_d     = !(!wr_op_d && ((state_d == ST_SETUP) || (state_d == ST_PULSE)));
      we_d     = !(wr_op_d && (state_d == ST_PULSE));
      drv_d    = wr_op_d && active_d;
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_DONE);
   end

   // State and output registers; reset parks every strobe inactive and floats the bus.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         wr_op_q <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         ce_q    <= 1'b1;
         oe_q    <= 1'b1;
         we_q    <= 1'b1;
         drv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_op_q <= wr_op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         drv_q   <= drv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign NF_A       = addr_q;
   assign NF_D       = drv_q ? wdata_q : 8'bzzzz_zzzz;
   assign NF_CE      = ce_q;
   assign NF_OE      = oe_q;
   assign NF_WE      = we_q;
   assign NF_BYTE    = 1'b0;
   assign NF_RP      = 1'b1;
   assign NF_WP      = 1'b1;
   assign host.rdata = rdata_q;
   assign host.busy  = busy_q;
   assign host.done  = done_q;

endmodule

// File: tb/tb_flash_ctrl.sv
// Bench for flash_ctrl: default-timing and 1/1/1-timing instances, each on its own flash model.
// Transactions are checked cycle by cycle against phase windows derived from the timing parameters.
// Requests are also poked while busy to confirm they are dropped.
module tb_flash_ctrl;

   logic CLK;
   logic RST;
   logic sel_fast;
   logic probe;
   logic model_en;

   flash_ctrl_if bus_d ();
   flash_ctrl_if bus_f ();

   logic [7:0] a_d, a_f;
   wire  [7:0] nfd_d, nfd_f;
   logic ce_d, oe_d, we_d, byte_d, rp_d, wp_d;
   logic ce_f, oe_f, we_f, byte_f, rp_f, wp_f;

   logic [7:0] mem_d [256];
   logic [7:0] mem_f [256];
   logic [7:0] xm_d  [256];
   logic [7:0] xm_f  [256];
   logic [7:0] exp_rd [2];

   int n_chk;
   int n_err;

   flash_ctrl u_dut (
      .CLK(CLK), .RST(RST), .host(bus_d.slave),
      .NF_A(a_d), .NF_D(nfd_d), .NF_CE(ce_d), .NF_OE(oe_d), .NF_WE(we_d),
      .NF_BYTE(byte_d), .NF_RP(rp_d), .NF_WP(wp_d)
   );

   flash_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_fast (
      .CLK(CLK), .RST(RST), .host(bus_f.slave),
      .NF_A(a_f), .NF_D(nfd_f), .NF_CE(ce_f), .NF_OE(oe_f), .NF_WE(we_f),
      .NF_BYTE(byte_f), .NF_RP(rp_f), .NF_WP(wp_f)
   );

   // Flash device models: drive data while selected and output-enabled, else an optional probe pattern.
   assign nfd_d = (!ce_d && !oe_d) ? mem_d[a_d] : (probe ? 8'h96 : 8'hzz);
   assign nfd_f = (!ce_f && !oe_f) ? mem_f[a_f] : (probe ? 8'h96 : 8'hzz);

   // Program a byte on the rising edge of WE# while the chip is selected.
   always @(posedge we_d) if (model_en && !RST && !ce_d) mem_d[a_d] = nfd_d;
   always @(posedge we_f) if (model_en && !RST && !ce_f) mem_f[a_f] = nfd_f;

   // Observation of the instance under test.
   wire       o_ce    = sel_fast ? ce_f : ce_d;
   wire       o_oe    = sel_fast ? oe_f : oe_d;
   wire       o_we    = sel_fast ? we_f : we_d;
   wire [7:0] o_a     = sel_fast ? a_f : a_d;
   wire [7:0] o_nfd   = sel_fast ? nfd_f : nfd_d;
   wire [7:0] o_rdata = sel_fast ? bus_f.rdata : bus_d.rdata;
   wire       o_busy  = sel_fast ? bus_f.busy : bus_d.busy;
   wire       o_done  = sel_fast ? bus_f.done : bus_d.done;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (fast=%0d t=%0t): got %0h expected %0h", tag, sel_fast, $time, act, exp);
      end
   endtask

   task automatic set_req(input bit wr, input bit rd, input logic [7:0] ad, input logic [7:0] wd);
      if (sel_fast) begin
         bus_f.wr_req = wr; bus_f.rd_req = rd; bus_f.addr = ad; bus_f.wdata = wd;
      end else begin
         bus_d.wr_req = wr; bus_d.rd_req = rd; bus_d.addr = ad; bus_d.wdata = wd;
      end
   endtask

   task automatic chk_reset_pins(input string tag);
      chk({tag, "_ce"},    o_ce, 1);
      chk({tag, "_oe"},    o_oe, 1);
      chk({tag, "_we"},    o_we, 1);
      chk({tag, "_busy"},  o_busy, 0);
      chk({tag, "_done"},  o_done, 0);
      chk({tag, "_rdata"}, o_rdata, 8'h00);
      chk({tag, "_nfa"},   o_a, 8'h00);
      chk({tag, "_nfd_z"}, o_nfd, 8'h96);
   endtask

   // One transaction, called at a negedge with the controller idle; returns at a negedge, idle again.
   // poke_k: cycle index at which a one-cycle rd_req is pulsed while busy (-1: none).
   // abort_k: cycle index at which reset is asserted (-1: none).
   task automatic do_txn(input bit wr, input bit rd, input logic [7:0] ad, input logic [7:0] wd,
                         input int poke_k, input int abort_k);
      int s, p, h, n, oe_n, we_n, done_n;
      bit is_wr, is_rd;
      logic [7:0] r_prev, rd_val, r_exp;
      s = sel_fast ? 1 : 2;
      p = sel_fast ? 1 : 3;
      h = sel_fast ? 1 : 1;
      n = s + p + h;
      is_wr  = wr;
      is_rd  = !wr && rd;
      r_prev = exp_rd[sel_fast];
      rd_val = sel_fast ? xm_f[ad] : xm_d[ad];
      oe_n = 0; we_n = 0; done_n = 0;
      probe = is_rd;
      set_req(wr, rd, ad, wd);
      @(posedge CLK);
      #1 set_req(0, 0, ~ad, ~wd);
      for (int k = 0; k <= n + 1; k++) begin
         @(negedge CLK);
         if (k == abort_k) begin
            RST = 1'b1;
            probe = 1'b1;
            #1;
            exp_rd[0] = 8'h00;
            exp_rd[1] = 8'h00;
            chk_reset_pins("abort");
            @(posedge CLK);
            @(negedge CLK);
            chk("abort_hold_done", o_done, 0);
            chk("abort_hold_rdata", o_rdata, 8'h00);
            RST = 1'b0;
            return;
         end
         if (k == poke_k) set_req(0, 1, ad ^ 8'h55, wd);
         if (k == poke_k + 1) set_req(0, 0, ~ad, ~wd);
         chk("ce",   o_ce,   !(k < n));
         chk("oe",   o_oe,   !(is_rd && k < s + p));
         chk("we",   o_we,   !(is_wr && k >= s && k < s + p));
         chk("busy", o_busy, k <= n);
         chk("done", o_done, k == n);
         chk("nfa",  o_a,    ad);
         chk("strobe_excl", o_oe | o_we, 1);
         if (is_wr && k < n) chk("nfd_wr", o_nfd, wd);
         if (is_rd) chk(k < s + p ? "nfd_rd" : "nfd_z", o_nfd, k < s + p ? rd_val : 8'h96);
         r_exp = (is_rd && k >= s + p) ? rd_val : r_prev;
         chk("rdata", o_rdata, r_exp);
         if (!o_oe) oe_n++;
         if (!o_we) we_n++;
         if (o_done) done_n++;
      end
      chk("oe_width",  oe_n, is_rd ? s + p : 0);
      chk("we_width",  we_n, is_wr ? p : 0);
      chk("done_cnt",  done_n, 1);
      if (is_wr) begin
         if (sel_fast) xm_f[ad] = wd; else xm_d[ad] = wd;
         chk("model_mem", sel_fast ? mem_f[ad] : mem_d[ad], wd);
      end else begin
         exp_rd[sel_fast] = rd_val;
      end
   endtask

   task automatic rand_txns(input int cnt);
      int op, gap, poke;
      logic [7:0] ad, wd;
      for (int i = 0; i < cnt; i++) begin
         op   = int'($urandom_range(0, 2));
         ad   = 8'($urandom);
         if (ad == 8'hE0) ad = 8'hE1;
         wd   = 8'($urandom);
         gap  = int'($urandom_range(0, 2));
         poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sel_fast ? 3 : 6)) : -1;
         repeat (gap) @(negedge CLK);
         do_txn(op != 1, op != 0, ad, wd, poke, -1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_err = 0;
      sel_fast = 1'b0; probe = 1'b1; model_en = 1'b0;
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem_d[i] = 8'($urandom); xm_d[i] = mem_d[i];
         mem_f[i] = 8'($urandom); xm_f[i] = mem_f[i];
      end
      bus_d.rd_req = 0; bus_d.wr_req = 0; bus_d.addr = 8'h00; bus_d.wdata = 8'h00;
      bus_f.rd_req = 0; bus_f.wr_req = 0; bus_f.addr = 8'h00; bus_f.wdata = 8'h00;
      RST = 1'b0;
      #1 RST = 1'b1;
      #2;
      chk_reset_pins("rst_d");
      chk("tie_byte", byte_d, 0);
      chk("tie_rp", rp_d, 1);
      chk("tie_wp", wp_d, 1);
      sel_fast = 1'b1;
      chk_reset_pins("rst_f");
      chk("tie_byte_f", byte_f, 0);
      sel_fast = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_reset_pins("rst_held");
      RST = 1'b0;
      model_en = 1'b1;

      // Default timing instance.
      do_txn(1, 0, 8'h3C, 8'hA5, -1, -1);
      mem_d[8'h10] = 8'h5A; xm_d[8'h10] = 8'h5A;
      do_txn(0, 1, 8'h10, 8'h00, -1, -1);
      do_txn(1, 1, 8'h20, 8'h77, -1, -1);
      do_txn(0, 1, 8'h20, 8'h00, -1, -1);
      do_txn(1, 0, 8'h44, 8'hC3, 3, -1);
      do_txn(0, 1, 8'h44, 8'h00, 5, -1);
      rand_txns(20);
      do_txn(0, 1, 8'h3C, 8'h00, -1, -1);
      do_txn(1, 0, 8'hE0, 8'h11, -1, 3);
      do_txn(0, 1, 8'h3C, 8'h00, -1, -1);

      // Minimum timing instance.
      sel_fast = 1'b1;
      do_txn(1, 0, 8'h3C, 8'hA5, -1, -1);
      do_txn(0, 1, 8'h3C, 8'h00, -1, -1);
      do_txn(1, 1, 8'h20, 8'h77, 1, -1);
      do_txn(0, 1, 8'h20, 8'h00, 0, -1);
      rand_txns(15);
      do_txn(1, 0, 8'hE0, 8'h22, -1, 1);
      do_txn(0, 1, 8'h20, 8'h00, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
